// File: rtl/fb_pkg.sv
// Frame-buffer arbiter shared definitions: geometry, widths and the slot tags
// that travel down the arbiter's two-stage access pipeline.
package fb_pkg;

  localparam int FB_W      = 300;
  localparam int FB_H      = 300;
  localparam int FB_PIXELS = 90000;
  localparam int FB_AW     = 17;
  localparam int FB_DW     = 8;

  typedef enum logic [2:0] {
    TAG_NONE,
    TAG_DISP,
    TAG_DISP_MISS,
    TAG_CPU_RD,
    TAG_CPU_WR,
    TAG_CPU_ERR
  } slot_tag_e;

  // A slot carries the display outcome and the CPU outcome separately,
  // because a forced CPU grant and a missed display request share one cycle.
  typedef struct packed {
    slot_tag_e disp_tag;
    slot_tag_e cpu_tag;
    logic      err_rd;
  } slot_t;

  localparam slot_t SLOT_IDLE = '{disp_tag: TAG_NONE, cpu_tag: TAG_NONE, err_rd: 1'b0};

endpackage

// File: rtl/fb_starve_guard.sv
// CPU starvation guard for the frame-buffer arbiter (built only when
// FB_STARVE_GUARD_EN is defined). Counts cycles the CPU waits with a pending
// request; when the count reaches STARVE_MAX the CPU is forced through.
module fb_starve_guard
  import fb_pkg::*;
#(
  parameter int STARVE_MAX = 16
)(
  input  logic VGA_CLK_IN,
  input  logic rst_n,
  input  logic cpu_req,
  input  logic cpu_grant,
  output logic force_cpu
);

  localparam logic [7:0] WAIT_LIMIT = 8'(STARVE_MAX);

  logic [7:0] wait_cnt;

  // Count ungranted request cycles; any grant or an idle CPU restarts the count.
  always_ff @(posedge VGA_CLK_IN or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 8'd0;
    end else if (!cpu_req || cpu_grant) begin
      wait_cnt <= 8'd0;
    end else if (wait_cnt != 8'hFF) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign force_cpu = cpu_req && (wait_cnt == WAIT_LIMIT);

endmodule

// File: rtl/fb_arbiter.sv
// Single-port frame-buffer arbiter: shares the image RAM between VGA scan-out
// (fixed latency 3, priority) and the CPU load/store port (idle cycles only).
// Optional feature macro: FB_STARVE_GUARD_EN adds a CPU starvation guard that
// forces a CPU grant after STARVE_MAX waits; the displaced display request is
// answered with the previously returned pixel and disp_miss.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int PIXELS     = FB_PIXELS,
  parameter int AW         = FB_AW,
  parameter int DW         = FB_DW,
  parameter int STARVE_MAX = 16
)(
  input  logic          VGA_CLK_IN,
  input  logic          rst_n,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_valid,
  output logic [DW-1:0] disp_data,
  output logic          disp_miss,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic          cpu_err,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [AW:0] PIX_LIMIT = (AW+1)'(PIXELS);

  logic  force_cpu;
  logic  addr_err;
  logic  disp_grant;
  logic  cpu_grant;
  logic  disp_preempt;
  slot_t slot_nxt;
  slot_t slot_s1;
  slot_t slot_s2;

  assign addr_err = ({1'b0, cpu_addr} >= PIX_LIMIT);

`ifdef FB_STARVE_GUARD_EN
  fb_starve_guard #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_guard (
    .VGA_CLK_IN (VGA_CLK_IN),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_grant  (cpu_grant),
    .force_cpu  (force_cpu)
  );
`else
  logic unused_starve_max;
  assign unused_starve_max = (STARVE_MAX == 0);
  assign force_cpu         = 1'b0;
`endif

  // Grant selection: forced CPU, then display, then CPU in idle cycles.
  always_comb begin
    disp_grant   = 1'b0;
    cpu_grant    = 1'b0;
    disp_preempt = 1'b0;
    if (force_cpu) begin
      cpu_grant    = 1'b1;
      disp_preempt = disp_req;
    end else if (disp_req) begin
      disp_grant = 1'b1;
    end else if (cpu_req) begin
      cpu_grant = 1'b1;
    end
  end

  // Tag the slot issued this cycle so the return stage knows whom to answer.
  always_comb begin
    slot_nxt = SLOT_IDLE;
    if (disp_grant) begin
      slot_nxt.disp_tag = TAG_DISP;
    end else if (disp_preempt) begin
      slot_nxt.disp_tag = TAG_DISP_MISS;
    end
    if (cpu_grant) begin
      if (addr_err) begin
        slot_nxt.cpu_tag = TAG_CPU_ERR;
        slot_nxt.err_rd  = !cpu_we;
      end else if (cpu_we) begin
        slot_nxt.cpu_tag = TAG_CPU_WR;
      end else begin
        slot_nxt.cpu_tag = TAG_CPU_RD;
      end
    end
  end

  // Issue stage: drive the RAM port and acknowledge the CPU one cycle after grant.
  always_ff @(posedge VGA_CLK_IN or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      cpu_ack   <= 1'b0;
      cpu_err   <= 1'b0;
    end else begin
      cpu_ack <= cpu_grant;
      cpu_err <= cpu_grant && addr_err;
      mem_we  <= cpu_grant && cpu_we && !addr_err;
      if (disp_grant) begin
        mem_addr <= disp_addr;
      end else if (cpu_grant && !addr_err) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end
    end
  end

  // Tag pipeline aligned with the RAM's one-cycle read latency.
  always_ff @(posedge VGA_CLK_IN or negedge rst_n) begin
    if (!rst_n) begin
      slot_s1 <= SLOT_IDLE;
      slot_s2 <= SLOT_IDLE;
    end else begin
      slot_s1 <= slot_nxt;
      slot_s2 <= slot_s1;
    end
  end

  // Return stage: capture RAM data for the owner of the slot; a missed display
  // slot keeps disp_data, which repeats the last pixel actually fetched.
  always_ff @(posedge VGA_CLK_IN or negedge rst_n) begin
    if (!rst_n) begin
      disp_valid <= 1'b0;
      disp_miss  <= 1'b0;
      disp_data  <= '0;
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
    end else begin
      disp_valid <= (slot_s2.disp_tag != TAG_NONE);
      disp_miss  <= (slot_s2.disp_tag == TAG_DISP_MISS);
      if (slot_s2.disp_tag == TAG_DISP) begin
        disp_data <= mem_rdata;
      end
      cpu_rvalid <= (slot_s2.cpu_tag == TAG_CPU_RD) ||
                    ((slot_s2.cpu_tag == TAG_CPU_ERR) && slot_s2.err_rd);
      if (slot_s2.cpu_tag == TAG_CPU_RD) begin
        cpu_rdata <= mem_rdata;
      end else if ((slot_s2.cpu_tag == TAG_CPU_ERR) && slot_s2.err_rd) begin
        cpu_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter. Display and CPU read returns are
// predicted into queues when requests are driven and retired by a monitor at
// the cycle they are due. The starvation scenario follows FB_STARVE_GUARD_EN.
module tb_fb_arbiter;

  localparam int AW = 17;
  localparam int DW = 8;

  logic          VGA_CLK_IN = 1'b0;
  logic          rst_n;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_valid;
  logic [DW-1:0] disp_data;
  logic          disp_miss;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic          cpu_err;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  typedef struct {
    int        due;
    logic [7:0] data;
    logic      miss;
  } exp_t;

  exp_t       dq[$];
  exp_t       cq[$];
  int         cyc    = 0;
  int         n_chk  = 0;
  int         n_pass = 0;
  int         n_fail = 0;
  logic [7:0] last_disp = 8'd0;
  logic [7:0] wmem [int];

  always #5 VGA_CLK_IN = ~VGA_CLK_IN;

  fb_arbiter #(
    .PIXELS     (90000),
    .AW         (AW),
    .DW         (DW),
    .STARVE_MAX (4)
  ) dut (
    .VGA_CLK_IN (VGA_CLK_IN),
    .rst_n      (rst_n),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .disp_valid (disp_valid),
    .disp_data  (disp_data),
    .disp_miss  (disp_miss),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_err    (cpu_err),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always @(posedge VGA_CLK_IN) cyc <= cyc + 1;

  // Synchronous RAM: unwritten locations read as (address + 1).
  always @(posedge VGA_CLK_IN) begin
    mem_rdata <= wmem.exists(int'(mem_addr)) ? wmem[int'(mem_addr)] : 8'(int'(mem_addr) + 1);
    if (mem_we) wmem[int'(mem_addr)] = mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge VGA_CLK_IN);
  endtask

  task automatic push_disp(input logic [7:0] d);
    dq.push_back('{cyc + 3, d, 1'b0});
    last_disp = d;
  endtask

  task automatic push_miss();
    dq.push_back('{cyc + 3, last_disp, 1'b1});
  endtask

  // Hold a CPU command until acknowledged (bounded), then check the issue cycle.
  task automatic cpu_cmd(input logic we, input logic [AW-1:0] a, input logic [7:0] wd,
                         input int exp_wait, input logic exp_err, input logic [7:0] exp_rd);
    int waits = 0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    tick();
    while (!cpu_ack && waits < 50) begin
      waits++;
      tick();
    end
    check("cpu_wait", waits, exp_wait);
    check("cpu_err", cpu_err, exp_err);
    check("cpu_mem_we", mem_we, we && !exp_err);
    if (we && !exp_err) begin
      check("cpu_mem_addr", mem_addr, a);
      check("cpu_mem_wdata", mem_wdata, wd);
    end
    if (!we && cpu_ack) cq.push_back('{cyc + 2, exp_rd, 1'b0});
    cpu_req = 1'b0;
  endtask

  // Retire predictions at their due cycle; any valid without one is an error.
  always @(negedge VGA_CLK_IN) begin
    exp_t e;
    logic ev;
    logic cv;
    ev = (dq.size() > 0) && (dq[0].due == cyc);
    check("disp_valid", disp_valid, ev);
    if (ev) begin
      e = dq.pop_front();
      check("disp_data", disp_data, e.data);
      check("disp_miss", disp_miss, e.miss);
    end
    cv = (cq.size() > 0) && (cq[0].due == cyc);
    check("cpu_rvalid", cpu_rvalid, cv);
    if (cv) begin
      e = cq.pop_front();
      check("cpu_rdata", cpu_rdata, e.data);
    end
  end

  initial begin
    rst_n = 1'b0; disp_req = 1'b0; disp_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    tick(2);
    check("rst_flags", {disp_valid, disp_miss, cpu_ack, cpu_err, cpu_rvalid, mem_we}, 0);
    check("rst_data", {disp_data, cpu_rdata, mem_wdata}, 0);
    check("rst_addr", mem_addr, 0);
    rst_n = 1'b1;
    tick(2);

    // Display-only burst, back to back.
    for (int i = 0; i < 10; i++) begin
      disp_req = 1'b1; disp_addr = AW'(i);
      push_disp(8'(i + 1));
      tick();
      if (i == 3) begin
        check("disp_mem_addr", mem_addr, 3);
        check("disp_mem_we", mem_we, 0);
      end
    end
    disp_req = 1'b0;
    tick(4);

    // CPU write then read back.
    cpu_cmd(1'b1, AW'(1234), 8'h5A, 0, 1'b0, 8'h00);
    tick();
    check("wr_we_one_cycle", mem_we, 0);
    check("ack_one_cycle", cpu_ack, 0);
    cpu_cmd(1'b0, AW'(1234), 8'h00, 0, 1'b0, 8'h5A);
    tick(4);

    // Last in-range pixel.
    cpu_cmd(1'b0, AW'(89999), 8'h00, 0, 1'b0, 8'h90);
    tick(4);

    // Collision: display first, CPU one cycle later.
    disp_req = 1'b1; disp_addr = AW'(20); push_disp(8'd21);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'(5);
    tick();
    disp_req = 1'b0;
    check("coll_no_ack", cpu_ack, 0);
    check("coll_mem_disp", mem_addr, 20);
    tick();
    check("coll_ack", cpu_ack, 1);
    check("coll_mem_cpu", mem_addr, 5);
    cq.push_back('{cyc + 2, 8'd6, 1'b0});
    cpu_req = 1'b0;
    tick(4);

    // Out-of-range CPU read and write; out-of-range display read is unchecked.
    cpu_cmd(1'b0, AW'(90000), 8'h00, 0, 1'b1, 8'h00);
    tick(4);
    cpu_cmd(1'b1, AW'(90001), 8'hFF, 0, 1'b1, 8'h00);
    tick(4);
    disp_req = 1'b1; disp_addr = AW'(100000); push_disp(8'hA1);
    tick();
    disp_req = 1'b0;
    tick(4);

`ifdef FB_STARVE_GUARD_EN
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'(7);
    for (int i = 0; i < 8; i++) begin
      check("guard_ack", cpu_ack, (i == 5));
      if (i == 5) cpu_req = 1'b0;
      disp_req = 1'b1; disp_addr = AW'(40 + i);
      if (i == 4) begin
        push_miss();
        cq.push_back('{cyc + 3, 8'd8, 1'b0});
      end else begin
        push_disp(8'(41 + i));
      end
      tick();
    end
    disp_req = 1'b0;
    tick(5);
`else
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'(7);
    for (int i = 0; i < 8; i++) begin
      check("starve_no_ack", cpu_ack, 0);
      disp_req = 1'b1; disp_addr = AW'(40 + i);
      push_disp(8'(41 + i));
      tick();
    end
    disp_req = 1'b0;
    check("starve_still_waiting", cpu_ack, 0);
    tick();
    check("starve_ack", cpu_ack, 1);
    cq.push_back('{cyc + 2, 8'd8, 1'b0});
    cpu_req = 1'b0;
    tick(5);
`endif

    // Reset with a display slot and a CPU read in flight.
    disp_req = 1'b1; disp_addr = AW'(50);
    tick();
    disp_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'(9);
    tick();
    check("rst_pre_ack", cpu_ack, 1);
    cpu_req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_flags", {disp_valid, disp_miss, cpu_ack, cpu_err, cpu_rvalid, mem_we}, 0);
    check("midrst_data", {disp_data, cpu_rdata, mem_wdata}, 0);
    check("midrst_addr", mem_addr, 0);
    tick(2);
    rst_n = 1'b1;
    last_disp = 8'd0;
    tick(6);

    // Recovery after reset.
    disp_req = 1'b1; disp_addr = AW'(3); push_disp(8'd4);
    tick();
    disp_req = 1'b0;
    tick(5);

    check("disp_queue_empty", dq.size(), 0);
    check("cpu_queue_empty", cq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
